// File: rtl/pc_ifid_stage.sv
// Fetch stage: owns the PC and the IF/ID register, obeys stall-controller hold
// requests, applies (or defers) branch/jump redirects and counts stall/flush events.
module pc_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PC_WriteEn,
    input  logic             IFID_WriteEn,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      IFID_PC4,
    output logic [31:0]      IFID_Instr,
    output logic             IFID_Valid,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0] pcReg;
    logic [31:0] pcPlus4;
    logic [31:0] redirectTarget;
    logic [31:0] nextPc;
    logic        pendValid;
    logic [31:0] pendPc;
    logic        pendApply;
    logic        ifidFlush;
    logic        flushEvent;
    logic        unusedAlignBits;

    assign redirectTarget  = {redirect_pc[31:2], 2'b00};
    assign unusedAlignBits = ^redirect_pc[1:0];
    assign pcPlus4         = pcReg + 32'd4;
    assign imem_addr       = pcReg;

    // A live redirect always beats a queued one; the queued target is only
    // consumed on a cycle where the PC is allowed to move.
    always_comb begin
        nextPc    = pcPlus4;
        pendApply = 1'b0;
        if (redirect) begin
            nextPc = redirectTarget;
        end else if (pendValid) begin
            nextPc    = pendPc;
            pendApply = PC_WriteEn;
        end
    end

    // Only the accepting redirect is a counted flush event. Applying a queued
    // target still bubbles IF/ID so the stale sequential fetch never enters ID.
    always_comb begin
        flushEvent = redirect;
        ifidFlush  = redirect | pendApply;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg <= RESET_PC;
        end else if (PC_WriteEn) begin
            pcReg <= nextPc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pendValid <= 1'b0;
            pendPc    <= 32'h0000_0000;
        end else if (PC_WriteEn) begin
            pendValid <= 1'b0;
        end else if (redirect) begin
            pendValid <= 1'b1;
            pendPc    <= redirectTarget;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            IFID_PC4   <= 32'h0000_0000;
            IFID_Instr <= NOP_INSTR;
            IFID_Valid <= 1'b0;
        end else if (ifidFlush) begin
            IFID_Instr <= NOP_INSTR;
            IFID_Valid <= 1'b0;
        end else if (IFID_WriteEn) begin
            IFID_Instr <= imem_rdata;
            IFID_PC4   <= pcPlus4;
            IFID_Valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!PC_WriteEn && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flushEvent && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    pcAligned: assert property (@(posedge clk) disable iff (reset) pcReg[1:0] == 2'b00);
    pendAligned: assert property (@(posedge clk) disable iff (reset) pendPc[1:0] == 2'b00);

endmodule

// File: tb/tb_pc_ifid_stage.sv
// Bench for pc_ifid_stage: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the fetch stage.
module tb_pc_ifid_stage;

    localparam int          CNT_W  = 8;
    localparam int          CMAX   = (1 << CNT_W) - 1;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'hDEAD_0013;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             PC_WriteEn = 1'b0;
    logic             IFID_WriteEn = 1'b0;
    logic             redirect = 1'b0;
    logic [31:0]      redirect_pc = 32'h0;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      IFID_PC4;
    logic [31:0]      IFID_Instr;
    logic             IFID_Valid;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mPc, mPc4, mInstr;
    logic        mValid;
    logic [31:0] pendQ[$];
    int          mStall, mFlush;

    pc_ifid_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .PC_WriteEn(PC_WriteEn), .IFID_WriteEn(IFID_WriteEn),
        .redirect(redirect), .redirect_pc(redirect_pc), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .IFID_PC4(IFID_PC4), .IFID_Instr(IFID_Instr),
        .IFID_Valid(IFID_Valid), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    // One clock of the fetch stage, from its rules, using the pre-edge state.
    task automatic model_step(input logic rst, input logic pwe, input logic iwe,
                              input logic red, input logic [31:0] rpc);
        logic [31:0] tgt;
        logic        usePend;
        if (rst) begin
            mPc = RST_PC; mPc4 = 0; mInstr = NOP; mValid = 0;
            pendQ.delete(); mStall = 0; mFlush = 0;
        end else begin
            tgt = rpc & 32'hFFFF_FFFC;
            usePend = pwe && !red && (pendQ.size() > 0);
            if (red || usePend) begin
                mInstr = NOP; mValid = 0;
            end else if (iwe) begin
                mInstr = memWord(mPc); mPc4 = mPc + 4; mValid = 1;
            end
            if (pwe) begin
                if (red) mPc = tgt;
                else if (pendQ.size() > 0) mPc = pendQ[0];
                else mPc = mPc + 4;
                pendQ.delete();
            end else if (red) begin
                pendQ.delete();
                pendQ.push_back(tgt);
            end
            if (!pwe) mStall = (mStall < CMAX) ? mStall + 1 : CMAX;
            if (red) mFlush = (mFlush < CMAX) ? mFlush + 1 : CMAX;
        end
    endtask

    // Drive one cycle at the falling edge; outputs are sampled at the next falling edge.
    task automatic step(input logic rst, input logic pwe, input logic iwe,
                        input logic red, input logic [31:0] rpc);
        reset = rst; PC_WriteEn = pwe; IFID_WriteEn = iwe; redirect = red; redirect_pc = rpc;
        model_step(rst, pwe, iwe, red, rpc);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_free(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1, 0, 32'h0);
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0, 32'h0);
        step(1, 1, 1, 1, 32'h1234);
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", imem_addr, RST_PC); end
        checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", IFID_Valid); end
        checks++; if (IFID_Instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", IFID_Instr, NOP); end
        checks++; if (IFID_PC4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", IFID_PC4); end
        checks++; if (stall_cycles !== '0 || flush_count !== '0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cycles, flush_count); end
    endtask

    task automatic test_free_run;
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 1, 0, 32'h0);
            checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL free_pc got %h exp %h", imem_addr, 32'(4 * i)); end
            checks++; if (IFID_Valid !== 1'b1 || IFID_PC4 !== 32'(4 * i)) begin
                errors++; $display("FAIL free_ifid got v=%b pc4=%h exp v=1 pc4=%h", IFID_Valid, IFID_PC4, 32'(4 * i)); end
            checks++; if (IFID_Instr !== memWord(32'(4 * (i - 1)))) begin
                errors++; $display("FAIL free_instr got %h exp %h", IFID_Instr, memWord(32'(4 * (i - 1)))); end
        end
    endtask

    task automatic test_stall;
        step(1, 0, 0, 0, 32'h0);
        run_free(8);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 32'h0);
            checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL stall_pc got %h exp 00000020", imem_addr); end
            checks++; if (IFID_Instr !== memWord(32'h1C) || IFID_PC4 !== 32'h20 || IFID_Valid !== 1'b1) begin
                errors++; $display("FAIL stall_ifid got %h/%h/%b exp %h/00000020/1", IFID_Instr, IFID_PC4, IFID_Valid, memWord(32'h1C)); end
        end
        checks++; if (stall_cycles !== CNT_W'(3)) begin errors++; $display("FAIL stall_count got %0d exp 3", stall_cycles); end
    endtask

    task automatic test_redirect;
        step(1, 0, 0, 0, 32'h0);
        run_free(16);
        step(0, 1, 1, 1, 32'h103);
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_pc got %h exp 00000100", imem_addr); end
        checks++; if (IFID_Valid !== 1'b0 || IFID_Instr !== NOP || IFID_PC4 !== 32'h40) begin
            errors++; $display("FAIL redir_bubble got %b/%h/%h exp 0/%h/00000040", IFID_Valid, IFID_Instr, IFID_PC4, NOP); end
        checks++; if (flush_count !== CNT_W'(1)) begin errors++; $display("FAIL redir_flush got %0d exp 1", flush_count); end
        step(0, 1, 1, 0, 32'h0);
        checks++; if (imem_addr !== 32'h104 || IFID_Valid !== 1'b1 || IFID_Instr !== memWord(32'h100) || IFID_PC4 !== 32'h104) begin
            errors++; $display("FAIL redir_target got pc=%h v=%b i=%h p4=%h exp pc=00000104 v=1 i=%h p4=00000104",
                               imem_addr, IFID_Valid, IFID_Instr, IFID_PC4, memWord(32'h100)); end
    endtask

    task automatic test_pend;
        step(1, 0, 0, 0, 32'h0);
        run_free(4);
        step(0, 0, 0, 1, 32'h200);
        step(0, 0, 0, 0, 32'h0);
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL pend_hold_pc got %h exp 00000010", imem_addr); end
        checks++; if (flush_count !== CNT_W'(1) || stall_cycles !== CNT_W'(2)) begin
            errors++; $display("FAIL pend_counts got %0d/%0d exp 1/2", flush_count, stall_cycles); end
        step(0, 1, 1, 0, 32'h0);
        checks++; if (imem_addr !== 32'h200 || IFID_Valid !== 1'b0) begin
            errors++; $display("FAIL pend_apply got pc=%h v=%b exp pc=00000200 v=0", imem_addr, IFID_Valid); end
        checks++; if (flush_count !== CNT_W'(1)) begin errors++; $display("FAIL pend_single_flush got %0d exp 1", flush_count); end
        step(0, 1, 1, 0, 32'h0);
        checks++; if (imem_addr !== 32'h204 || IFID_Instr !== memWord(32'h200) || IFID_Valid !== 1'b1) begin
            errors++; $display("FAIL pend_target_instr got pc=%h i=%h exp pc=00000204 i=%h", imem_addr, IFID_Instr, memWord(32'h200)); end
        step(0, 0, 0, 1, 32'h300);
        step(0, 0, 0, 1, 32'h407);
        step(0, 1, 1, 0, 32'h0);
        checks++; if (imem_addr !== 32'h404 || flush_count !== CNT_W'(3)) begin
            errors++; $display("FAIL pend_overwrite got pc=%h f=%0d exp pc=00000404 f=3", imem_addr, flush_count); end
        step(0, 0, 0, 1, 32'h500);
        step(0, 1, 1, 1, 32'h600);
        step(0, 1, 1, 0, 32'h0);
        checks++; if (imem_addr !== 32'h604 || flush_count !== CNT_W'(5)) begin
            errors++; $display("FAIL pend_redirect_wins got pc=%h f=%0d exp pc=00000604 f=5", imem_addr, flush_count); end
    endtask

    task automatic test_wrap;
        step(1, 0, 0, 0, 32'h0);
        step(0, 1, 1, 1, 32'hFFFF_FFFE);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h exp fffffffc", imem_addr); end
        step(0, 1, 1, 0, 32'h0);
        checks++; if (imem_addr !== 32'h0 || IFID_PC4 !== 32'h0 || IFID_Instr !== memWord(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap got pc=%h p4=%h i=%h exp 0/0/%h", imem_addr, IFID_PC4, IFID_Instr, memWord(32'hFFFF_FFFC)); end
    endtask

    task automatic test_saturation;
        step(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < CMAX + 40; i++) step(0, 0, 0, 1, $urandom);
        checks++; if (stall_cycles !== CNT_W'(CMAX) || flush_count !== CNT_W'(CMAX)) begin
            errors++; $display("FAIL sat_reach got %0d/%0d exp %0d/%0d", stall_cycles, flush_count, CMAX, CMAX); end
        step(0, 0, 0, 1, 32'h80);
        step(0, 1, 1, 1, 32'h80);
        checks++; if (stall_cycles !== CNT_W'(CMAX) || flush_count !== CNT_W'(CMAX)) begin
            errors++; $display("FAIL sat_hold got %0d/%0d exp %0d/%0d", stall_cycles, flush_count, CMAX, CMAX); end
    endtask

    task automatic test_reset_pend;
        step(1, 0, 0, 0, 32'h0);
        run_free(2);
        step(0, 0, 0, 1, 32'h700);
        step(1, 0, 0, 0, 32'h0);
        checks++; if (imem_addr !== RST_PC || stall_cycles !== '0 || flush_count !== '0) begin
            errors++; $display("FAIL rst_pend got pc=%h s=%0d f=%0d exp %h/0/0", imem_addr, stall_cycles, flush_count, RST_PC); end
        step(0, 1, 1, 0, 32'h0);
        checks++; if (imem_addr !== RST_PC + 32'd4) begin errors++; $display("FAIL rst_pend_lost got %h exp %h", imem_addr, RST_PC + 32'd4); end
    endtask

    task automatic test_random;
        logic r, p, w, d;
        step(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 63) == 0);
            p = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 5) == 0);
            step(r, p, w, d, $urandom);
            checks++; if (imem_addr !== mPc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, imem_addr, mPc); end
            checks++; if (IFID_PC4 !== mPc4) begin errors++; $display("FAIL rnd_pc4 cyc %0d got %h exp %h", i, IFID_PC4, mPc4); end
            checks++; if (IFID_Instr !== mInstr) begin errors++; $display("FAIL rnd_instr cyc %0d got %h exp %h", i, IFID_Instr, mInstr); end
            checks++; if (IFID_Valid !== mValid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, IFID_Valid, mValid); end
            checks++; if (stall_cycles !== CNT_W'(mStall)) begin errors++; $display("FAIL rnd_stall cyc %0d got %0d exp %0d", i, stall_cycles, mStall); end
            checks++; if (flush_count !== CNT_W'(mFlush)) begin errors++; $display("FAIL rnd_flush cyc %0d got %0d exp %0d", i, flush_count, mFlush); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_pend();
        test_wrap();
        test_saturation();
        test_reset_pend();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
